prog_clk_gen: RTL
=================

PROG_CLK_GEN -- requirements
Module: prog_clk_gen

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of independent clock-enable channels.
REQ-002 SHALL have parameter CNT_W, default 16: width of the period and high-time fields.
REQ-003 SHALL have parameter DEF_PERIOD, default 10: reset period, in clk cycles.
REQ-004 SHALL have parameter DEF_HIGH, default 7: reset high time, in cycles (70% duty).
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port en, input, NUM_CH bits: per-channel run enable (level).
REQ-008 SHALL have port cfg_valid, input, 1 bit: configuration write request.
REQ-009 SHALL have port cfg_ready, output, 1 bit: configuration write can be accepted.
REQ-010 SHALL have port cfg_ch, input, CH_W bits: target channel, where CH_W = max(1, clog2(NUM_CH)).
REQ-011 SHALL have port cfg_period, input, CNT_W bits: new period, in cycles.
REQ-012 SHALL have port cfg_high, input, CNT_W bits: new high time, in cycles.
REQ-013 SHALL have port clk_out, output, NUM_CH bits: registered generated waveform per channel.
REQ-014 SHALL have port period_start, output, NUM_CH bits: one-cycle pulse on the first cycle of each period.

Function
REQ-015 Each channel SHALL hold active registers act_period and act_high, shadow registers shd_period and shd_high, a pending flag, and a counter cnt.
REQ-016 With en[i]=1, each edge SHALL compute cnt_n = 0 if cnt == act_period-1, else cnt+1; this wrap at act_period-1 is the "wrap".
REQ-017 On the same edge, clk_out[i] SHALL be loaded with (cnt_n < act_high_n), using the active values in effect after that edge.
REQ-018 Consequently the waveform SHALL be high for act_high cycles, then low for act_period-act_high cycles.
REQ-019 The first cycle after en rises SHALL have cnt=0 and clk_out = (act_high > 0).
REQ-020 period_start[i] SHALL be registered and high exactly in the cycles where en[i]=1 and cnt=0.
REQ-021 Boundary: act_high = 0 SHALL give a constant-low output.
REQ-022 Boundary: act_high >= act_period SHALL give a constant-high output.
REQ-023 Boundary: act_period < 2 SHALL force cnt=0 and clk_out=0, with period_start still asserted.
REQ-024 With en[i]=0, the edge SHALL set cnt=0, clk_out[i]=0 and period_start[i]=0.
REQ-025 Disabling SHALL take effect on the first edge after en falls, including mid-period.
REQ-026 cfg_ready SHALL be combinational and equal !pending[cfg_ch].
REQ-027 If cfg_ch >= NUM_CH, cfg_ready SHALL be 1.
REQ-028 A handshake (cfg_valid && cfg_ready) SHALL load shd_period and shd_high of channel cfg_ch and set pending.
REQ-029 A handshake to an out-of-range cfg_ch SHALL be accepted and discarded, with no state change.
REQ-030 A pending update SHALL be applied on the edge where the channel wraps, or on any edge while en[i]=0.
REQ-031 Applying SHALL copy shadow to active, clear pending, and make the new values govern the period starting at that edge.
REQ-032 A period in progress SHALL therefore never be truncated or stretched, so reconfiguration is glitch-free.
REQ-033 cfg_ready for a channel SHALL return high on the cycle after its update is applied.
REQ-034 Channels SHALL be fully independent; one channel's updates or enables SHALL NOT affect another.

Reset
REQ-035 While rst_n=0, the block SHALL immediately (asynchronously) force clk_out=0, period_start=0 and cnt=0.
REQ-036 While rst_n=0, act_period and shd_period SHALL be DEF_PERIOD.
REQ-037 While rst_n=0, act_high and shd_high SHALL be DEF_HIGH, and pending SHALL be 0.
REQ-038 Reset asserted mid-period SHALL discard any pending update.
REQ-039 After reset release, an enabled channel SHALL restart at cnt=0 on the first edge.

Structure
REQ-040 Package prog_clk_pkg SHALL hold the default constants (DEF_PERIOD, DEF_HIGH, CNT_W) and the per-channel config struct {period, high}.
REQ-041 Per-channel logic SHALL be a single sub-module prog_clk_chan, instantiated NUM_CH times.
REQ-042 The top level SHALL contain only cfg decode, cfg_ready muxing and the instances.

Verification
REQ-043 Reset, then en[0]=1 -> clk_out[0] is 1 for 7 cycles, 0 for 3, repeating; period_start[0] pulses every 10 cycles; other channels stay 0.
REQ-044 Write ch0 period=4, high=1 when cnt=3 -> the 10-cycle period completes unchanged, then 1-high/3-low; cfg_ready(ch0)=0 until the wrap and 1 the cycle after.
REQ-045 Writes high=0, then high=12 with period=10, then period=1 -> output constant 0, constant 1, constant 0 respectively; period_start behaves per REQ-020.
REQ-046 Drop en[1] at cnt=2 -> next cycle clk_out[1]=0 and cnt=0; re-enable -> the high phase restarts with full length.
REQ-047 Assert rst_n=0 mid-high phase with an update pending -> clk_out drops without waiting for clk; after release, a 7/3 waveform with the update lost.
REQ-048 With NUM_CH=3, write cfg_ch=3 -> cfg_ready=1, handshake completes, all channel waveforms unchanged.

Source files
------------

// File: rtl/prog_clk_pkg.sv
// Shared constants, per-channel configuration type and elaboration helpers
// for the programmable clock-enable generator.
package prog_clk_pkg;

  localparam int CNT_W      = 16;
  localparam int DEF_PERIOD = 10;
  localparam int DEF_HIGH   = 7;

  typedef struct packed {
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high;
  } cfg_t;

  // A single-channel build still needs a one-bit channel select.
  function automatic int chWidth(input int numCh);
    return (numCh > 1) ? $clog2(numCh) : 1;
  endfunction

  function automatic cfg_t makeCfg(input int period, input int high);
    cfg_t c;
    c.period = CNT_W'(period);
    c.high   = CNT_W'(high);
    return c;
  endfunction

endpackage

// File: rtl/prog_clk_chan.sv
// One clock-enable channel: period counter, double-buffered period/high
// configuration and registered waveform / period-start outputs.
module prog_clk_chan
  import prog_clk_pkg::*;
#(
  parameter int RST_PERIOD = DEF_PERIOD,
  parameter int RST_HIGH   = DEF_HIGH
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  input  logic i_cfgWr,
  input  cfg_t i_cfgNew,
  output logic o_pending,
  output logic o_clkOut,
  output logic o_periodStart
);

  localparam cfg_t RST_CFG = makeCfg(RST_PERIOD, RST_HIGH);

  cfg_t             r_act;
  cfg_t             r_shd;
  logic             r_pending;
  logic             r_run;
  logic [CNT_W-1:0] r_cnt;
  logic             r_clkOut;
  logic             r_periodStart;

  logic             w_short;
  logic             w_wrap;
  logic             w_apply;
  logic [CNT_W-1:0] w_cntNext;
  cfg_t             w_actNext;
  logic             w_shortNext;
  logic [CNT_W-1:0] w_cntOut;

  // The first enabled edge after idle also counts as a period boundary, so
  // the channel always starts at cnt=0 and picks up any queued update.
  assign w_short     = (r_act.period < CNT_W'(2));
  assign w_wrap      = !r_run || w_short || (r_cnt == r_act.period - CNT_W'(1));
  assign w_apply     = w_wrap && r_pending;
  assign w_cntNext   = w_wrap ? '0 : r_cnt + CNT_W'(1);
  assign w_actNext   = w_apply ? r_shd : r_act;
  assign w_shortNext = (w_actNext.period < CNT_W'(2));
  assign w_cntOut    = w_shortNext ? '0 : w_cntNext;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_act         <= RST_CFG;
      r_shd         <= RST_CFG;
      r_pending     <= 1'b0;
      r_run         <= 1'b0;
      r_cnt         <= '0;
      r_clkOut      <= 1'b0;
      r_periodStart <= 1'b0;
    end else begin
      if (i_en) begin
        r_run         <= 1'b1;
        r_cnt         <= w_cntOut;
        r_act         <= w_actNext;
        r_clkOut      <= !w_shortNext && (w_cntOut < w_actNext.high);
        r_periodStart <= (w_cntOut == '0);
        if (w_apply) begin
          r_pending <= 1'b0;
        end
      end else begin
        r_run         <= 1'b0;
        r_cnt         <= '0;
        r_clkOut      <= 1'b0;
        r_periodStart <= 1'b0;
        if (r_pending) begin
          r_act     <= r_shd;
          r_pending <= 1'b0;
        end
      end
      // A write is only accepted while nothing is pending, so it never
      // collides with the clear above.
      if (i_cfgWr) begin
        r_shd     <= i_cfgNew;
        r_pending <= 1'b1;
      end
    end
  end

  assign o_pending     = r_pending;
  assign o_clkOut      = r_clkOut;
  assign o_periodStart = r_periodStart;

endmodule

// File: rtl/prog_clk_gen.sv
// Programmable multi-channel clock-enable generator: configuration decode,
// ready muxing and one prog_clk_chan instance per channel.
module prog_clk_gen
  import prog_clk_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int CNT_W      = prog_clk_pkg::CNT_W,
  parameter int DEF_PERIOD = prog_clk_pkg::DEF_PERIOD,
  parameter int DEF_HIGH   = prog_clk_pkg::DEF_HIGH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_CH-1:0]            en,
  input  logic                         cfg_valid,
  output logic                         cfg_ready,
  input  logic [chWidth(NUM_CH)-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]             cfg_period,
  input  logic [CNT_W-1:0]             cfg_high,
  output logic [NUM_CH-1:0]            clk_out,
  output logic [NUM_CH-1:0]            period_start
);

  localparam int CH_W = chWidth(NUM_CH);

  cfg_t              w_cfgNew;
  logic [NUM_CH-1:0] w_cfgWr;
  logic [NUM_CH-1:0] w_pending;

  assign w_cfgNew.period = cfg_period;
  assign w_cfgNew.high   = cfg_high;

  // Out-of-range channel numbers match nothing, so they stay ready and the
  // write is silently dropped.
  always_comb begin
    cfg_ready = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg_ch == CH_W'(i)) begin
        cfg_ready = !w_pending[i];
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : gChan
    assign w_cfgWr[g] = cfg_valid && cfg_ready && (cfg_ch == CH_W'(g));

    prog_clk_chan #(
      .RST_PERIOD (DEF_PERIOD),
      .RST_HIGH   (DEF_HIGH)
    ) uChan (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .i_en          (en[g]),
      .i_cfgWr       (w_cfgWr[g]),
      .i_cfgNew      (w_cfgNew),
      .o_pending     (w_pending[g]),
      .o_clkOut      (clk_out[g]),
      .o_periodStart (period_start[g])
    );
  end

endmodule
